// File: rtl/kvs_resp_tracker_pkg.sv
// Shared KVS definitions: flag encodings, default field widths and the queued
// query entry layout used by the response tracker.
package kvs_pkg;

    localparam int DEF_KEY_SIZE  = 96;
    localparam int DEF_FLAG_SIZE = 4;

    typedef enum logic [DEF_FLAG_SIZE-1:0] {
        FLAG_NONE = 4'b0000,
        FLAG_GET  = 4'b0001,
        FLAG_SET  = 4'b0010,
        FLAG_DEL  = 4'b0100,
        FLAG_HIT  = 4'b1000
    } kvs_flag_e;

    typedef struct packed {
        logic [DEF_KEY_SIZE-1:0]  key;
        logic [DEF_FLAG_SIZE-1:0] flag;
    } kvs_entry_t;

    localparam int ENTRY_W = $bits(kvs_entry_t);

    function automatic int unsigned entry_width(input int unsigned key_size,
                                                input int unsigned flag_size);
        return key_size + flag_size;
    endfunction

endpackage

// File: rtl/kvs_resp_tracker_if.sv
// Query/response/match bundle between the query issuer, the database strobes
// and the tracker. The tracker is the slave; the issuer side is the master.
interface kvs_resp_tracker_if
    import kvs_pkg::*;
#(
    parameter int KEY_SIZE  = DEF_KEY_SIZE,
    parameter int FLAG_SIZE = DEF_FLAG_SIZE
) ();

    logic                 req_valid;
    logic [KEY_SIZE-1:0]  req_key;
    logic [FLAG_SIZE-1:0] req_flag;
    logic                 req_ready;

    logic                 resp_valid;
    logic [FLAG_SIZE-1:0] resp_flag;

    logic                 match_valid;
    logic [KEY_SIZE-1:0]  match_key;
    logic [FLAG_SIZE-1:0] match_req_flag;
    logic [FLAG_SIZE-1:0] match_resp_flag;
    logic                 match_timeout;

    modport master (
        output req_valid, req_key, req_flag, resp_valid, resp_flag,
        input  req_ready, match_valid, match_key, match_req_flag,
               match_resp_flag, match_timeout
    );

    modport slave (
        input  req_valid, req_key, req_flag, resp_valid, resp_flag,
        output req_ready, match_valid, match_key, match_req_flag,
               match_resp_flag, match_timeout
    );

endinterface

// File: rtl/kvs_resp_tracker_req_fifo.sv
// Show-ahead FIFO holding outstanding queries; rd_data always presents the
// head entry and count gives the registered occupancy.
module kvs_req_fifo #(
    parameter int WIDTH      = 100,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  sys_rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] head;
    logic [DEPTH_LOG2-1:0] tail;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[head];

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_wr) tail <= tail + 1'b1;
            if (do_rd) head <= head + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: only slots behind a valid pointer are ever read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[tail] <= wr_data;
    end

endmodule

// File: rtl/kvs_resp_tracker.sv
// Pairs database responses with the oldest issued query, retires stale head
// entries on timeout and flags orphan responses / dropped queries.
module kvs_resp_tracker
    import kvs_pkg::*;
#(
    parameter int KEY_SIZE   = DEF_KEY_SIZE,
    parameter int FLAG_SIZE  = DEF_FLAG_SIZE,
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 sys_rst_n,
    kvs_resp_tracker_if.slave    bus,
    output logic [DEPTH_LOG2:0]  outstanding,
    output logic                 err_orphan,
    output logic                 err_overflow
);

    localparam int unsigned EW    = entry_width(KEY_SIZE, FLAG_SIZE);
    localparam int unsigned AGE_W = $clog2(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT - 1);

    logic [EW-1:0]          head_data;
    logic [DEPTH_LOG2:0]    count;
    logic                   full;
    logic                   empty;
    logic                   push;
    logic                   pop_resp;
    logic                   pop_to;
    logic                   pop;
    logic [AGE_W-1:0]       age;

    logic                   match_valid_q;
    logic [KEY_SIZE-1:0]    match_key_q;
    logic [FLAG_SIZE-1:0]   match_req_flag_q;
    logic [FLAG_SIZE-1:0]   match_resp_flag_q;
    logic                   match_timeout_q;

    // A response only retires an entry present at the start of the cycle, so
    // both pop sources look at registered emptiness; response beats timeout.
    assign push     = bus.req_valid && !full;
    assign pop_resp = bus.resp_valid && !empty;
    assign pop_to   = !bus.resp_valid && !empty && (age == AGE_LAST);
    assign pop      = pop_resp || pop_to;

    kvs_req_fifo #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .sys_rst_n  (sys_rst_n),
        .wr_en      (push),
        .wr_data    ({bus.req_key, bus.req_flag}),
        .rd_en      (pop),
        .rd_data    (head_data),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            age               <= '0;
            err_orphan        <= 1'b0;
            err_overflow      <= 1'b0;
            match_valid_q     <= 1'b0;
            match_key_q       <= '0;
            match_req_flag_q  <= '0;
            match_resp_flag_q <= '0;
            match_timeout_q   <= 1'b0;
        end else begin
            if (empty || pop) age <= '0;
            else              age <= age + 1'b1;

            if (bus.resp_valid && empty) err_orphan   <= 1'b1;
            if (bus.req_valid && full)   err_overflow <= 1'b1;

            match_valid_q <= pop;
            if (pop) begin
                match_key_q       <= head_data[EW-1:FLAG_SIZE];
                match_req_flag_q  <= head_data[FLAG_SIZE-1:0];
                match_resp_flag_q <= pop_resp ? bus.resp_flag : '0;
                match_timeout_q   <= pop_to;
            end
        end
    end

    assign bus.req_ready       = !full;
    assign bus.match_valid     = match_valid_q;
    assign bus.match_key       = match_key_q;
    assign bus.match_req_flag  = match_req_flag_q;
    assign bus.match_resp_flag = match_resp_flag_q;
    assign bus.match_timeout   = match_timeout_q;
    assign outstanding         = count;

endmodule

// File: doc/kvs_resp_tracker.md
Name: kvs_resp_tracker

Overview:
Sits on the network side of the KVS interface, in the db_clk domain, between the query issuer and the database. It records each key query as it is issued to the database (in_key/in_flag/in_valid) in an in-order outstanding queue. It pairs each database response (out_valid/out_flag) with the oldest outstanding query and emits a matched result carrying the key, request flag and response flag, so the frame builder can act on it. Queries the database never answers are retired by a head-of-queue timeout. Unsolicited responses are flagged as errors.

Parameters:
KEY_SIZE, 96, key width in bits.
FLAG_SIZE, 4, request/response flag width.
DEPTH_LOG2, 3, log2 of outstanding-queue depth (8 entries).
TIMEOUT, 1024, cycles the head entry may wait for a response before forced retirement (must be >= 2).

Ports:
clk  in  1  db_clk domain clock.
sys_rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  query issued this cycle (mirror of in_valid).
req_key  in  KEY_SIZE  query key (mirror of in_key).
req_flag  in  FLAG_SIZE  query flag (mirror of in_flag).
req_ready  out  1  queue not full; the issuer must hold req_valid low while this is low.
resp_valid  in  1  database response strobe (out_valid).
resp_flag  in  FLAG_SIZE  database response flag (out_flag).
match_valid  out  1  one-cycle strobe: result fields valid.
match_key  out  KEY_SIZE  key of the retired query.
match_req_flag  out  FLAG_SIZE  flag of the retired query.
match_resp_flag  out  FLAG_SIZE  response flag; 0 on timeout.
match_timeout  out  1  retirement was caused by timeout.
outstanding  out  DEPTH_LOG2+1  current queue occupancy.
err_orphan  out  1  sticky: response arrived while the queue was empty.
err_overflow  out  1  sticky: req_valid asserted while req_ready was low.

Behaviour:
- Reset: asynchronous assert, synchronous deassert. While sys_rst_n is low, all outputs are 0 except req_ready, which is 1. The queue, age counter and sticky errors are cleared. Reset mid-operation discards all outstanding entries with no match emitted.
- req_ready = (outstanding < 2^DEPTH_LOG2), computed from registered occupancy only. It does not consider a pop in the same cycle.
- Push: req_valid & req_ready writes {key, flag} at the tail; outstanding increments at the next edge.
- Overflow: req_valid & !req_ready drops the query and sets err_overflow. The queue is unchanged.
- Pop by response: resp_valid with outstanding > 0 pops the head. On the next cycle match_valid=1, match_key/match_req_flag come from the head entry, match_resp_flag=resp_flag and match_timeout=0. Latency is 1 cycle.
- Orphan: resp_valid with outstanding == 0 sets err_orphan and emits no match. This applies even if a push occurs in the same cycle, because a response can only retire an entry already present at the start of the cycle.
- Age counter:
  - Counts cycles while outstanding > 0 and no pop occurs.
  - Clears to 0 on any pop or when the queue is empty.
- Timeout pop: age == TIMEOUT-1 with no resp_valid pops the head. Next cycle: match_valid=1, match_timeout=1, match_resp_flag=0.
- Simultaneous response and timeout: the response wins, the match is a normal one, and the age is cleared.
- Simultaneous push and pop: outstanding is unchanged, and the head/tail pointers each advance. Pointers wrap modulo 2^DEPTH_LOG2.
- At most one pop per cycle, so match_valid is never asserted on consecutive cycles for the same entry.
- Match output fields are registered and hold their last values when match_valid=0.

Decomposition:
- Package kvs_pkg holds:
  - flag encodings: FLAG_GET=4'b0001, FLAG_SET=4'b0010, FLAG_DEL=4'b0100, FLAG_HIT=4'b1000;
  - default KEY_SIZE and FLAG_SIZE;
  - the {key, flag} entry struct width constant.
- One sub-module: kvs_req_fifo. It is a synchronous show-ahead FIFO with an occupancy output, width KEY_SIZE+FLAG_SIZE and depth 2^DEPTH_LOG2. It uses the same clk/sys_rst_n.
- Pop arbitration, the age counter and error flags live in kvs_resp_tracker.

Test Plan:
1. Reset mid-operation. Push 3 queries, assert sys_rst_n low for 1 cycle, release, then send 1 response. Required: no match, err_orphan=1, outstanding=0, req_ready=1.
2. In-order pairing. Push keys 0x1, 0x2, 0x3 (flag GET), then send responses HIT, 0, HIT on separate cycles. Required: 3 matches in key order 0x1, 0x2, 0x3 with resp flags 8, 0, 8; each match 1 cycle after its response; outstanding returns to 0.
3. Full and overflow. Push 8 queries; req_ready falls after the 8th; a 9th req_valid is asserted. Required: err_overflow=1, outstanding=8. The 8 subsequent responses match the first 8 keys.
4. Timeout. TIMEOUT=16; push key 0xAA with no response. Required: match_valid 16 cycles after push, match_timeout=1, match_resp_flag=0, outstanding=0.
5. Response/timeout tie. Drive resp_valid with flag HIT exactly on the cycle the age reaches TIMEOUT-1. Required: single match, match_timeout=0, resp flag 8.
6. Wrap-around with simultaneous push and pop. Stream 20 queries while responding one cycle behind each. Required: outstanding stays at 1, all 20 keys match in order, no error flags set.
